// File: rtl/prog_lut_mux.sv
// Programmable K-input LUT: registered 2^K:1 mux over a double-buffered, serially loaded truth table.
// Optional macro LUT_READBACK_EN adds the tbl_q readback port of the committed table.
module prog_lut_mux #(
    parameter int K = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic              cfg_valid,
    input  logic              cfg_bit,
    output logic              cfg_ready,
    output logic              cfg_done,
    input  logic [K-1:0]      sel,
    input  logic              in_valid,
    output logic              y,
    output logic              y_valid,
    output logic              tbl_valid
`ifdef LUT_READBACK_EN
    ,
    output logic [(1<<K)-1:0] tbl_q
`endif
);

    localparam int unsigned N    = 1 << K;
    localparam logic [K:0]  LAST = (K+1)'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t         state;
    logic [N-1:0]   shadow;
    logic [N-1:0]   active;
    logic [K:0]     cnt;
    logic [N-1:0]   shadow_merged;

    // Shadow with the current serial bit already written, so the final bit can commit in the same edge.
    always_comb begin
        shadow_merged                = shadow;
        shadow_merged[cnt[K-1:0]]    = cfg_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shadow    <= '0;
            active    <= '0;
            cnt       <= '0;
            tbl_valid <= 1'b0;
            cfg_ready <= 1'b0;
            cfg_done  <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        state     <= LOAD;
                        cnt       <= '0;
                        cfg_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (cfg_start) begin
                        cnt <= '0;
                    end else if (cfg_valid) begin
                        shadow <= shadow_merged;
                        cnt    <= cnt + (K+1)'(1);
                        if (cnt == LAST) begin
                            active    <= shadow_merged;
                            tbl_valid <= 1'b1;
                            state     <= IDLE;
                            cfg_ready <= 1'b0;
                            cfg_done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Evaluation reads the pre-edge active table, so a result sampled on the commit edge uses the old function.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y       <= 1'b0;
            y_valid <= 1'b0;
        end else if (in_valid && tbl_valid) begin
            y       <= active[sel];
            y_valid <= 1'b1;
        end else begin
            y_valid <= 1'b0;
        end
    end

`ifdef LUT_READBACK_EN
    assign tbl_q = active;
`endif

endmodule

// File: tb/tb_prog_lut_mux.sv
// Directed self-checking bench for prog_lut_mux with K=2.
module tb_prog_lut_mux;

    localparam int K = 2;
    localparam int N = 4;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         cfg_start = 1'b0;
    logic         cfg_valid = 1'b0;
    logic         cfg_bit   = 1'b0;
    logic         in_valid  = 1'b0;
    logic [K-1:0] sel       = '0;
    logic         cfg_ready, cfg_done, y, y_valid, tbl_valid;
`ifdef LUT_READBACK_EN
    logic [N-1:0] tbl_q;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;

    prog_lut_mux #(.K(K)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .sel       (sel),
        .in_valid  (in_valid),
        .y         (y),
        .y_valid   (y_valid),
        .tbl_valid (tbl_valid)
`ifdef LUT_READBACK_EN
        ,
        .tbl_q     (tbl_q)
`endif
    );

    initial forever #5 clk = ~clk;

    always @(negedge clk) if (cfg_done === 1'b1) n_done++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_seq(input logic [N-1:0] t);
        int d0;
        d0 = n_done;
        cfg_start = 1'b1;
        tick();
        chk("load_ready_after_start", cfg_ready, 1);
        cfg_start = 1'b0;
        for (int i = 0; i < N; i++) begin
            cfg_valid = 1'b1;
            cfg_bit   = t[i];
            tick();
            if (i < N - 1) begin
                chk($sformatf("load_ready_bit%0d", i), cfg_ready, 1);
                chk($sformatf("load_nodone_bit%0d", i), cfg_done, 0);
            end
        end
        cfg_valid = 1'b0;
        chk("load_done_pulse", cfg_done, 1);
        chk("load_ready_drop", cfg_ready, 0);
        chk("load_tbl_valid", tbl_valid, 1);
`ifdef LUT_READBACK_EN
        chk("load_tbl_q", tbl_q, t);
`endif
        tick();
        chk("load_done_one_cycle", cfg_done, 0);
        chk("load_done_count", n_done - d0, 1);
    endtask

    task automatic sweep(input logic [N-1:0] t);
        for (int s = 0; s < N; s++) begin
            sel      = K'(s);
            in_valid = 1'b1;
            tick();
            chk($sformatf("sweep_y_sel%0d", s), y, t[s]);
            chk($sformatf("sweep_yv_sel%0d", s), y_valid, 1);
        end
        in_valid = 1'b0;
        tick();
        chk("sweep_yv_idle", y_valid, 0);
    endtask

    initial begin
        logic [N-1:0] old_t;
        logic [N-1:0] new_t;
        logic [N-1:0] exp_t;
        logic [N-1:0] gap_bits;
        int           d0;
        int           b;

        // Reset values while rst_n is held low
        #12;
        chk("rst_y", y, 0);
        chk("rst_y_valid", y_valid, 0);
        chk("rst_cfg_ready", cfg_ready, 0);
        chk("rst_cfg_done", cfg_done, 0);
        chk("rst_tbl_valid", tbl_valid, 0);
`ifdef LUT_READBACK_EN
        chk("rst_tbl_q", tbl_q, 0);
`endif
        rst_n = 1'b1;

        // No committed table: evaluation requests are ignored
        in_valid = 1'b1;
        sel      = 2'd3;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("notbl_y_valid", y_valid, 0);
            chk("notbl_y", y, 0);
            chk("notbl_tbl_valid", tbl_valid, 0);
        end
        in_valid = 1'b0;

        // First load 1100, then sweep
        load_seq(4'b1100);
        sweep(4'b1100);

        // Reload 1001 while sweeping; commit edge is the 4th bit (c==4)
        old_t = 4'b1100;
        new_t = 4'b1001;
        d0    = n_done;
        for (int c = 0; c < 10; c++) begin
            cfg_start = (c == 0);
            cfg_valid = (c >= 1 && c <= 4);
            cfg_bit   = (c >= 1 && c <= 4) ? new_t[c-1] : 1'b0;
            sel       = K'(c % 4);
            in_valid  = 1'b1;
            tick();
            exp_t = (c <= 4) ? old_t : new_t;
            chk($sformatf("swap_y_c%0d", c), y, exp_t[c % 4]);
            chk($sformatf("swap_done_c%0d", c), cfg_done, (c == 4));
        end
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        in_valid  = 1'b0;
        chk("swap_done_count", n_done - d0, 1);
`ifdef LUT_READBACK_EN
        chk("swap_tbl_q", tbl_q, 4'b1001);
`endif

        // cfg_valid in IDLE is ignored
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        tick();
        chk("idle_ready_lo", cfg_ready, 0);
        tick();
        chk("idle_ready_lo2", cfg_ready, 0);
        chk("idle_no_done", cfg_done, 0);
        cfg_valid = 1'b0;

        // Gapped load, restart after 2 bits (restart cycle carries a discarded bit), reload 0110 gapped
        d0 = n_done;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b1; cfg_bit = 1'b1; tick();
        cfg_valid = 1'b0;                 tick();
        cfg_valid = 1'b1; cfg_bit = 1'b1; tick();
        cfg_start = 1'b1; cfg_valid = 1'b1; cfg_bit = 1'b1;
        tick();
        chk("restart_ready", cfg_ready, 1);
        chk("restart_nodone", cfg_done, 0);
        cfg_start = 1'b0;
        gap_bits  = 4'b0110;
        b         = 0;
        in_valid  = 1'b1;
        sel       = 2'd0;
        for (int c = 1; c <= 7; c++) begin
            cfg_valid = (c == 1 || c == 3 || c == 4 || c == 7);
            cfg_bit   = cfg_valid ? gap_bits[b] : 1'b0;
            if (cfg_valid) b++;
            tick();
            chk($sformatf("gap_old_y_c%0d", c), y, 1);
        end
        chk("gap_done_pulse", cfg_done, 1);
        cfg_valid = 1'b0;
        tick();
        chk("gap_new_y", y, 0);
        chk("gap_done_one_cycle", cfg_done, 0);
        chk("gap_done_count", n_done - d0, 1);
        in_valid = 1'b0;
        sweep(4'b0110);

        // Reset in the middle of a load
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b1; cfg_bit = 1'b1; tick();
        cfg_bit   = 1'b0;                 tick();
        cfg_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("midrst_tbl_valid", tbl_valid, 0);
        chk("midrst_cfg_ready", cfg_ready, 0);
        chk("midrst_y", y, 0);
        chk("midrst_y_valid", y_valid, 0);
`ifdef LUT_READBACK_EN
        chk("midrst_tbl_q", tbl_q, 0);
`endif
        rst_n    = 1'b1;
        in_valid = 1'b1;
        sel      = 2'd2;
        tick();
        chk("postrst_y_valid", y_valid, 0);
        chk("postrst_cfg_ready", cfg_ready, 0);
        in_valid = 1'b0;
        load_seq(4'b1100);
        sweep(4'b1100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_lut_mux.md
# prog_lut_mux

Programmable K-input logic function built as a registered 2^K:1 multiplexer whose data inputs come from a loadable truth-table register. The select inputs index the table, and the selected bit is registered to the output, so one block can implement any K-input boolean function. The table is loaded serially and double-buffered. Evaluation continues on the old function while a new one loads, and the new function takes effect atomically. It sits in the combinational-function library as the reconfigurable successor to the fixed-constant mux function blocks.

## Interface
- K, 2: number of select inputs; table depth N = 2^K; legal range 1..6.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- cfg_start  input  1  begin a new table load; clears the shift counter.
- cfg_valid  input  1  cfg_bit is valid this cycle.
- cfg_bit  input  1  serial table bit; first bit accepted is entry 0.
- cfg_ready  output  1  high while in LOAD (bits are accepted).
- cfg_done  output  1  one-cycle pulse on the cycle after commit.
- sel  input  K  function inputs (table index).
- in_valid  input  1  sample sel this cycle.
- y  output  1  registered table[sel].
- y_valid  output  1  y holds a fresh result.
- tbl_valid  output  1  active table holds a committed function.

## Operation
- Storage:
  - shadow[N-1:0] is the shift register.
  - active[N-1:0] is the evaluation table.
  - cnt is a K+1-bit counter of accepted bits.
- FSM states: IDLE, LOAD.
  - IDLE → LOAD when cfg_start=1. cnt ← 0.
  - LOAD: a bit is accepted when cfg_valid=1. shadow[cnt] ← cfg_bit and cnt ← cnt+1.
  - LOAD, when the accepted bit is bit N-1 (cnt==N-1): active ← shadow with that bit merged, tbl_valid ← 1, then → IDLE.
  - cfg_start in LOAD restarts the load: cnt ← 0, and shadow contents are kept but will be overwritten.
  - cfg_start has priority over cfg_valid in the same cycle. That cycle's bit is discarded.
- Evaluation runs in either state.
  - If in_valid=1 and tbl_valid=1, then y ← active[sel] and y_valid ← 1.
  - Otherwise y_valid ← 0 and y holds its value.
- When tbl_valid=0, in_valid is ignored: y_valid stays 0 and y stays 0.
- Commit edge: an evaluation sampled on the same edge as the commit uses the old active table. The first evaluation to use the new table is the one sampled on the next edge.
- cfg_valid in IDLE is ignored. cfg_ready=0 in IDLE.
- There is no partial commit. A load that is restarted or interrupted by reset never changes active.

## Timing
- Reset (asynchronous, rst_n=0):
  - FSM goes to IDLE.
  - shadow, active and cnt are cleared to 0.
  - y, y_valid, cfg_ready, cfg_done and tbl_valid are all 0.
- Evaluation latency: sel and in_valid sampled at edge t appear as y/y_valid after edge t. Throughput is one result per cycle.
- Load latency: after cfg_start, at least N more cycles with cfg_valid=1 are needed.
  - cfg_ready goes high the cycle after cfg_start.
  - cfg_done pulses high for exactly one cycle, directly after the commit edge.
  - cfg_ready drops in that same cycle.
- cfg_start in IDLE and the final load bit cannot coincide, because bits are not accepted in IDLE.

## Configuration
- LUT_READBACK_EN defined: adds output port tbl_q [N-1:0], which is a direct copy of active (reset value 0). It updates on the commit edge.
- LUT_READBACK_EN undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then in_valid=1 with sel=3 for 5 cycles (K=2) → y_valid=0, y=0, tbl_valid=0 throughout.
- Load bits 0,0,1,1 (table 4'b1100) with no gaps, then sweep sel 0..3 → cfg_done pulses once 1 cycle after the 4th bit. y sequence is 0,0,1,1, each 1 cycle after its sel.
- With 4'b1100 active, load 1,0,0,1 while sweeping sel continuously.
  - Results sampled up to and including the commit edge use 1100.
  - From the next edge on, results follow 1001 (sel=0→1, sel=3→1).
- Load with cfg_valid gaps (bits on cycles 1,3,4,7), then assert cfg_start after 2 bits and reload 0110.
  - Only 0110 is committed.
  - Exactly one cfg_done pulse.
- Assert rst_n=0 after 2 of 4 load bits, then release → active=0, tbl_valid=0, FSM in IDLE, and the next load works normally.
- With LUT_READBACK_EN defined, load 1100 → tbl_q=4'b1100 from the commit edge on. It also equals 0 after reset.
